keys_event_sequencer: RTL and testbench
=======================================

Name: keys_event_sequencer

Overview:
- Hardware servicer for the key PIO (edge-capture, irq-mask and data registers on a 2-bit-address Avalon slave).
- On reset it programs the PIO irq mask.
- On each PIO irq it reads the edge-capture register, clears it, samples the key levels, and pushes one timestamp-free event word into a small FIFO.
- The CPU drains the FIFO through this block's own Avalon slave and no longer touches the PIO directly.

Parameters:
WIDTH, 3, number of key inputs; must match the PIO width
DEPTH, 8, event FIFO depth; power of 2, minimum 2
MASK_INIT, 3'b111, irq mask written to the PIO after reset

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m_address  out  2  PIO register select
m_chipselect  out  1  PIO chipselect
m_write_n  out  1  PIO write strobe, active low
m_writedata  out  32  PIO write data
m_readdata  in  32  PIO read data; registered, valid 1 cycle after the address is presented
pio_irq  in  1  PIO interrupt (level)
address  in  2  CPU slave register select
chipselect  in  1  CPU slave select
read  in  1  CPU read strobe
write_n  in  1  CPU write strobe, active low
writedata  in  32  CPU write data
readdata  out  32  CPU read data; registered, 1-cycle latency
irq  out  1  event-available interrupt to the CPU

Behaviour:
- Clock/reset: single clock clk. Reset is asynchronous, active-low, on reset_n.
- Reset values: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, readdata=0, irq=0. FIFO empty, overflow count 0, mask register=MASK_INIT, irq_enable=0. FSM enters INIT_MASK.
- Master FSM states and transitions:
  - INIT_MASK: one cycle, chipselect=1, write_n=0, address=2, writedata=mask. Next state IDLE.
  - IDLE: a pending mask write has priority and goes to WR_MASK. Otherwise pio_irq=1 goes to CAP_ADDR.
  - WR_MASK: same bus cycle as INIT_MASK. Clears the pending flag. Next state IDLE.
  - CAP_ADDR: address=3, chipselect=0.
  - CAP_WAIT: sample m_readdata[WIDTH-1:0] into cap.
    - cap==0 (spurious): go to IDLE with no write.
    - Otherwise: go to CAP_CLR.
  - CAP_CLR: write address 3, data 0. Clears all PIO edge bits; pio_irq falls the next cycle.
  - LVL_ADDR: address=0.
  - LVL_WAIT: sample the level into lvl.
  - PUSH: enqueue {cap, lvl}, or drop if the FIFO is full. Next state IDLE.
- Service latency: 7 cycles from IDLE with pio_irq high to the event visible in the FIFO.
- Known limitation: an edge captured by the PIO between CAP_WAIT and CAP_CLR is lost. This is accepted and must be documented in the driver.
- Event word: [WIDTH-1:0]=level, [WIDTH+3:4]=edges, [31]=valid, all other bits 0.
- CPU slave register map:
  - addr0 read: head event with valid=1. If the FIFO is empty, returns all-zero and does not pop. chipselect&read on a non-empty FIFO pops exactly one entry.
  - addr1 read: status. [7:0] overflow count (saturates at 255), [15:8] fill count, [16] empty, [17] full.
  - addr1 write: clears the overflow count.
  - addr2: mask register, R/W. A write updates the register and sets the pending flag. A repeated write before service just updates the value; one WR_MASK is issued with the latest value.
  - addr3: [0] irq_enable, R/W.
  - Unused read bits return 0.
- Write qualification: writes are qualified by chipselect & ~write_n.
- irq = irq_enable & ~empty, registered.
- FIFO boundaries:
  - Push when full: drop the event and increment overflow (saturating).
  - Push and pop in the same cycle: both occur and the count is unchanged. When full, the simultaneous pop frees the slot first and the push succeeds.
  - Pointers wrap modulo DEPTH.
- Reset mid-service: the bus returns to idle immediately, the partial event is discarded, and INIT_MASK re-runs.

Decomposition:
- Shared package:
  - master FSM state enum (INIT_MASK, IDLE, WR_MASK, CAP_ADDR, CAP_WAIT, CAP_CLR, LVL_ADDR, LVL_WAIT, PUSH);
  - PIO register offsets (DATA=0, MASK=2, EDGE=3);
  - slave offsets;
  - event field positions.
- One sub-module: keys_event_fifo (synchronous FIFO, parameters DEPTH and data width, with full, empty and count outputs).

Test Plan:
- Reset release -> exactly one master write, address 2 with data 3'b111, then the bus stays idle; readdata=0, irq=0.
- Key[1] press, PIO model raises irq with edge=3'b010 and level=3'b010 -> the event sequence completes in 7 cycles. A CPU addr0 read returns 0x8000_0022 and the FIFO becomes empty.
- 9 events with no pops at DEPTH=8 -> status full=1, fill count=8, overflow=1. Eight pops return the events in order and a ninth pop returns 0.
- Pop and push in the same cycle with the FIFO full -> fill count stays 8 and overflow is unchanged.
- CPU writes mask=3'b001 during CAP_WAIT -> WR_MASK with data 1 is issued only after PUSH completes. A spurious irq with edge=0 produces no clear write and no push.
- reset_n asserted during LVL_ADDR -> outputs go to reset values asynchronously. After release, INIT_MASK re-runs and the FIFO is empty.

Source files
------------

// File: rtl/keys_event_sequencer_pkg.sv
// keys_event_sequencer_pkg: shared state encoding, register offsets and event layout
package keys_event_sequencer_pkg;
  typedef enum logic [3:0] {
    INIT_MASK, IDLE, WR_MASK, CAP_ADDR, CAP_WAIT, CAP_CLR, LVL_ADDR, LVL_WAIT, PUSH
  } state_t;
  localparam logic [1:0] PIO_DATA = 2'd0;
  localparam logic [1:0] PIO_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE = 2'd3;
  localparam logic [1:0] SLV_EVENT = 2'd0;
  localparam logic [1:0] SLV_STATUS = 2'd1;
  localparam logic [1:0] SLV_MASK = 2'd2;
  localparam logic [1:0] SLV_CTRL = 2'd3;
  localparam int EV_EDGE_LSB = 4;
  localparam int EV_VALID = 31;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_EMPTY = 16;
  localparam int ST_FULL = 17;
  function automatic logic [31:0] event_word(input logic [3:0] edges, input logic [3:0] level);
    logic [31:0] w;
    w = '0;
    w[EV_VALID] = 1'b1;
    w[EV_EDGE_LSB +: 4] = edges;
    w[3:0] = level;
    return w;
  endfunction
endpackage

// File: rtl/keys_event_sequencer_fifo.sv
// keys_event_fifo: synchronous FIFO with occupancy count; a pop frees a slot for a same-cycle push
module keys_event_fifo #(
  parameter int DEPTH = 8,
  parameter int DW = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count[AW];
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/keys_event_sequencer.sv
// keys_event_sequencer: services the key PIO on irq and queues {edges, levels} events for the CPU
// Edges the PIO captures between the edge read and its clear are lost; the driver must tolerate this.
module keys_event_sequencer
  import keys_event_sequencer_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter logic [WIDTH-1:0] MASK_INIT = WIDTH'(3'b111)
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        pio_irq,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_n;
  logic live, pend, irq_enable, full, empty, push, pop, drop, slv_wr;
  logic [WIDTH-1:0] mask, cap, lvl;
  logic [7:0] ovf;
  logic [2*WIDTH-1:0] head;
  logic [CW-1:0] count;
  logic [31:0] status, rdata;
  logic unused_bits;
  assign unused_bits = ^{m_readdata[31:WIDTH], writedata[31:WIDTH]};
  assign slv_wr = chipselect & ~write_n;
  assign pop = chipselect & read & (address == SLV_EVENT) & ~empty;
  assign push = state == PUSH;
  assign drop = push & full & ~pop;

  keys_event_fifo #(.DEPTH(DEPTH), .DW(2 * WIDTH)) fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .din({cap, lvl}),
    .dout(head), .full(full), .empty(empty), .count(count)
  );

  // live holds the bus idle during reset and for the first clock after it, so INIT_MASK drives exactly one write
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= INIT_MASK;
      live <= 1'b0;
    end else begin
      state <= state_n;
      live <= 1'b1;
    end

  always_comb begin
    state_n = state;
    m_chipselect = 1'b0;
    m_write_n = 1'b1;
    m_address = PIO_DATA;
    m_writedata = '0;
    case (state)
      INIT_MASK: state_n = live ? IDLE : INIT_MASK;
      IDLE:      state_n = pend ? WR_MASK : pio_irq ? CAP_ADDR : IDLE;
      CAP_ADDR:  state_n = CAP_WAIT;
      CAP_WAIT:  state_n = |m_readdata[WIDTH-1:0] ? CAP_CLR : IDLE;
      CAP_CLR:   state_n = LVL_ADDR;
      LVL_ADDR:  state_n = LVL_WAIT;
      LVL_WAIT:  state_n = PUSH;
      default:   state_n = IDLE;
    endcase
    if (live)
      case (state)
        INIT_MASK, WR_MASK: begin
          m_chipselect = 1'b1;
          m_write_n = 1'b0;
          m_address = PIO_MASK;
          m_writedata = 32'(mask);
        end
        CAP_ADDR, CAP_WAIT: m_address = PIO_EDGE;
        CAP_CLR: begin
          m_chipselect = 1'b1;
          m_write_n = 1'b0;
          m_address = PIO_EDGE;
        end
        default: m_address = PIO_DATA;
      endcase
  end

  always_comb begin
    status = '0;
    status[7:0] = ovf;
    status[ST_COUNT_LSB +: 8] = 8'(count);
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    rdata = address == SLV_EVENT ? (empty ? '0 : event_word(4'(head[2*WIDTH-1:WIDTH]), 4'(head[WIDTH-1:0])))
          : address == SLV_STATUS ? status
          : address == SLV_MASK ? 32'(mask)
          : 32'(irq_enable);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend <= 1'b0;
      mask <= MASK_INIT;
      irq_enable <= 1'b0;
      ovf <= '0;
      cap <= '0;
      lvl <= '0;
      readdata <= '0;
      irq <= 1'b0;
    end else begin
      if (state == CAP_WAIT) cap <= m_readdata[WIDTH-1:0];
      if (state == LVL_WAIT) lvl <= m_readdata[WIDTH-1:0];
      if (slv_wr && address == SLV_MASK) mask <= writedata[WIDTH-1:0];
      pend <= (slv_wr && address == SLV_MASK) | (pend & (state != WR_MASK));
      if (slv_wr && address == SLV_CTRL) irq_enable <= writedata[0];
      ovf <= (slv_wr && address == SLV_STATUS) ? '0 : (drop && ovf != 8'hff) ? ovf + 8'd1 : ovf;
      if (chipselect & read) readdata <= rdata;
      irq <= irq_enable & ~empty;
    end
endmodule

// File: tb/tb_keys_event_sequencer.sv
// tb_keys_event_sequencer: PIO model plus CPU-side scoreboard around keys_event_sequencer
module tb_keys_event_sequencer;
  logic clk = 0, reset_n = 0;
  logic [1:0] m_address, address = 0;
  logic m_chipselect, m_write_n, pio_irq, irq;
  logic chipselect = 0, read = 0, write_n = 1;
  logic [31:0] m_writedata, m_readdata, writedata = 0, readdata;
  logic [2:0] keys = 0, keys_q = 0, edge_r = 0, pmask = 0;
  logic spur = 0, rd_pend = 0;
  int n_cmp = 0, n_fail = 0, cyc_n = 0;

  typedef struct {logic [1:0] a; logic [31:0] d; int c;} wr_t;
  typedef struct {logic [31:0] e; string n;} sb_t;
  typedef struct {logic [2:0] keys; logic [31:0] exp;} vec_t;
  wr_t wlog[$];
  sb_t sb[$];
  vec_t vt[4];

  always #5 clk = ~clk;

  keys_event_sequencer dut (
    .clk(clk), .reset_n(reset_n), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata), .m_readdata(m_readdata), .pio_irq(pio_irq),
    .address(address), .chipselect(chipselect), .read(read), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  // PIO model: rising-edge capture, any write to the edge register clears it, registered readdata
  always @(posedge clk) begin
    keys_q <= keys;
    m_readdata <= m_address == 2'd3 ? {29'd0, edge_r} : m_address == 2'd0 ? {29'd0, keys}
                : m_address == 2'd2 ? {29'd0, pmask} : 32'd0;
    edge_r <= (m_chipselect && !m_write_n && m_address == 2'd3) ? 3'd0 : edge_r | (keys & ~keys_q);
    if (m_chipselect && !m_write_n && m_address == 2'd2) pmask <= m_writedata[2:0];
    if (m_chipselect && !m_write_n) wlog.push_back('{m_address, m_writedata, cyc_n});
    cyc_n <= cyc_n + 1;
    rd_pend <= chipselect & read;
  end
  assign pio_irq = |(edge_r & pmask) | spur;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rd_pend) begin
      sb_t s;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow: got read data %h expected no read", readdata);
      end else begin
        s = sb.pop_front();
        check(s.n, readdata, s.e);
      end
    end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_read(logic [1:0] a, logic [31:0] e, string nm);
    sb.push_back('{e, nm});
    address = a;
    chipselect = 1;
    read = 1;
    cyc();
    chipselect = 0;
    read = 0;
  endtask

  task automatic cpu_write(logic [1:0] a, logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1;
    write_n = 0;
    cyc();
    chipselect = 0;
    write_n = 1;
  endtask

  task automatic press(logic [2:0] p);
    keys = p;
    cyc(12);
    keys = 0;
    cyc(2);
  endtask

  task automatic wait_bus(string nm, logic [3:0] pat);
    int i;
    for (i = 0; i < 40; i++) begin
      if ({m_chipselect, m_write_n, m_address} == pat) break;
      cyc();
    end
    check(nm, {31'd0, i < 40}, 32'd1);
  endtask

  task automatic check_wr(string nm, int idx, logic [1:0] a, logic [31:0] d);
    if (wlog.size() > idx) begin
      check({nm, "_addr"}, {30'd0, wlog[idx].a}, {30'd0, a});
      check({nm, "_data"}, wlog[idx].d, d);
    end else check({nm, "_missing"}, wlog.size(), idx + 1);
  endtask

  function automatic logic [31:0] ev(logic [2:0] p);
    return 32'h8000_0000 | {24'd0, 1'b0, p, 1'b0, p};
  endfunction

  function automatic logic [2:0] pat(int i);
    return 3'((i % 7) + 1);
  endfunction

  initial begin
    int k;
    vt[0] = '{3'b001, 32'h8000_0011};
    vt[1] = '{3'b100, 32'h8000_0044};
    vt[2] = '{3'b101, 32'h8000_0055};
    vt[3] = '{3'b111, 32'h8000_0077};
    cyc(3);
    check("rst_cs", m_chipselect, 0);
    check("rst_wn", m_write_n, 1);
    check("rst_addr", m_address, 0);
    check("rst_wdata", m_writedata, 0);
    check("rst_readdata", readdata, 0);
    check("rst_irq", irq, 0);
    wlog.delete();
    reset_n = 1;
    cyc(10);
    check("init_wr_count", wlog.size(), 1);
    check_wr("init_wr", 0, 2'd2, 32'd7);
    check("post_init_readdata", readdata, 0);
    check("post_init_irq", irq, 0);
    cpu_read(2'd2, 32'd7, "mask_rd");
    cpu_read(2'd1, 32'h0001_0000, "status_empty");

    cpu_write(2'd3, 32'd1);
    cpu_read(2'd3, 32'd1, "irq_en_rd");
    wlog.delete();
    keys = 3'b010;
    for (int i = 0; i < 10 && !pio_irq; i++) cyc();
    k = 0;
    while (!irq && k < 20) begin
      cyc();
      k++;
    end
    check("irq_latency", k, 8);
    cyc(2);
    keys = 0;
    cyc(2);
    check("svc_wr_count", wlog.size(), 1);
    check_wr("cap_clr", 0, 2'd3, 32'd0);
    cpu_read(2'd0, 32'h8000_0022, "key1_event");
    cpu_read(2'd0, 32'd0, "key1_empty_pop");
    cpu_read(2'd1, 32'h0001_0000, "key1_status");
    check("irq_after_drain", irq, 0);

    foreach (vt[i]) begin
      press(vt[i].keys);
      cpu_read(2'd0, vt[i].exp, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 9; i++) press(pat(i));
    cpu_read(2'd1, 32'h0002_0801, "ovf_status_full");
    for (int i = 0; i < 8; i++) cpu_read(2'd0, ev(pat(i)), $sformatf("ovf_pop%0d", i));
    cpu_read(2'd0, 32'd0, "ovf_pop_empty");
    cpu_read(2'd1, 32'h0001_0001, "ovf_status_drained");
    cpu_write(2'd1, 32'd0);
    cpu_read(2'd1, 32'h0001_0000, "ovf_cleared");

    for (int i = 0; i < 8; i++) press(pat(i));
    keys = pat(8);
    wait_bus("pp_clr_seen", 4'b1011);
    cyc(3);
    cpu_read(2'd0, ev(pat(0)), "pp_pop_during_push");
    keys = 0;
    cyc(3);
    cpu_read(2'd1, 32'h0002_0800, "pp_status");
    for (int i = 1; i < 9; i++) cpu_read(2'd0, ev(pat(i)), $sformatf("pp_pop%0d", i));
    cpu_read(2'd1, 32'h0001_0000, "pp_status_empty");

    wlog.delete();
    keys = 3'b100;
    wait_bus("mw_cap_addr_seen", 4'b0111);
    cyc();
    cpu_write(2'd2, 32'd1);
    cyc(10);
    keys = 0;
    check("mw_wr_count", wlog.size(), 2);
    check_wr("mw_clr", 0, 2'd3, 32'd0);
    check_wr("mw_mask", 1, 2'd2, 32'd1);
    if (wlog.size() == 2) check("mw_mask_delay", wlog[1].c - wlog[0].c, 5);
    cpu_read(2'd2, 32'd1, "mw_mask_rd");
    cpu_read(2'd0, 32'h8000_0044, "mw_event");
    wlog.delete();
    spur = 1;
    cyc();
    spur = 0;
    cyc(10);
    check("spur_no_write", wlog.size(), 0);
    cpu_read(2'd1, 32'h0001_0000, "spur_no_push");

    press(3'b001);
    check("rr_irq_hi", irq, 1);
    cpu_read(2'd2, 32'd1, "rr_mask_rd");
    keys = 3'b001;
    wait_bus("rr_clr_seen", 4'b1011);
    cyc();
    reset_n = 0;
    #2;
    check("rr_cs", m_chipselect, 0);
    check("rr_wn", m_write_n, 1);
    check("rr_addr", m_address, 0);
    check("rr_readdata", readdata, 0);
    check("rr_irq", irq, 0);
    cyc(2);
    wlog.delete();
    reset_n = 1;
    keys = 0;
    cyc(10);
    check("rr_init_count", wlog.size(), 1);
    check_wr("rr_init", 0, 2'd2, 32'd7);
    cpu_read(2'd1, 32'h0001_0000, "rr_status");
    cpu_read(2'd3, 32'd0, "rr_irq_en");
    check("rr_irq_after", irq, 0);
    cyc(3);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
